// File: rtl/kmeans_seed_ctrl.sv
// Picks K distinct-or-not initial centroid indices from a free-running generator.
// Optional duplicate rejection: define SEED_DEDUP_EN.
module kmeans_seed_ctrl #(
  parameter int K         = 4,
  parameter int IDX_W     = 13,
  parameter int MAX_TRIES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [IDX_W-1:0]                  n_points,
  input  logic [IDX_W-1:0]                  rnd,
  output logic                              seed_valid,
  input  logic                              seed_ready,
  output logic [IDX_W-1:0]                  seed_idx_o,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0] seed_num,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] rd_addr,
  output logic [IDX_W-1:0]                  rd_idx,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = $clog2(K + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] np_q, np_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tries_q, tries_d, tries_inc;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    num_q, num_d;
  logic [IDX_W-1:0] tbl_q [K];
  logic             tbl_we;
  logic             dup;

`ifdef SEED_DEDUP_EN
  // Only slots already filled in this run take part in the match.
  always_comb begin
    dup = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (NW'(j) < cnt_q && tbl_q[j] == cand_q) dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign tries_inc = (tries_q == 8'(MAX_TRIES)) ? tries_q
                                                : tries_q + 8'd1;

  always_comb begin
    state_d = state_q;
    np_d    = np_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    err_d   = err_q;
    idx_d   = idx_q;
    num_d   = num_q;
    tbl_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          np_d    = n_points;
          cnt_d   = '0;
          tries_d = '0;
          err_d   = 1'b0;
          if (n_points == '0 || n_points < IDX_W'(K)) err_d = 1'b1;
          else state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        cand_d  = rnd;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cand_q >= np_q || dup) begin
          tries_d = tries_inc;
          if (tries_inc == 8'(MAX_TRIES)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SAMPLE;
          end
        end else begin
          tbl_we  = 1'b1;
          idx_d   = cand_q;
          num_d   = cnt_q[CW-1:0];
          tries_d = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (seed_ready) begin
          cnt_d = cnt_q + NW'(1);
          if (cnt_q == NW'(K - 1)) state_d = S_DONE;
          else state_d = S_SAMPLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      np_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      np_q    <= np_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[cnt_q[CW-1:0]] <= cand_q;
    end
  end

  assign rd_idx = (32'(rd_addr) < K) ? tbl_q[rd_addr] : '0;

  assign seed_valid = (state_q == S_EMIT);
  assign busy       = (state_q == S_SAMPLE) || (state_q == S_CHECK) ||
                      (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign seed_idx_o = idx_q;
  assign seed_num   = num_q;

endmodule
